booth_radix4_mult: RTL and testbench

BOOTH_RADIX4_MULT -- requirements
Module: booth_radix4_mult

---
 rtl/booth_radix4_mult_if.sv | 24 ++
 rtl/booth_radix4_mult.sv | 114 +++++++++++
 tb/tb_booth_radix4_mult.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_radix4_mult_if.sv
// Operand/result bundle for the radix-4 Booth multiplier.
// Master drives start and operands; slave returns busy, done and product.
// No flow control beyond start/busy/done: a start is taken only when idle.
interface booth_radix4_mult_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 mode_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, mode_signed, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, mode_signed, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands.
// Latency: WIDTH/2+1 cycles from the start edge to the done pulse.
// start is sampled only in IDLE; it is ignored while busy or in DONE.
module booth_radix4_mult #(
  parameter int WIDTH = 16
) (
  input logic               Clock,
  input logic               Reset_n,
  booth_radix4_mult_if.slave bus
);
  // Operands carry two extra bits so unsigned values stay positive and the
  // last Booth group sees a proper sign; the accumulator has two more bits
  // again so that +/-2M never overflows.
  localparam int EXT  = WIDTH + 2;
  localparam int AW   = WIDTH + 4;
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [EXT-1:0]    m_reg;
  logic [EXT-1:0]    q_reg;
  logic              q_m1;
  logic [AW-1:0]     acc;
  logic [CW-1:0]     cnt;
  logic              last;
  logic [EXT-1:0]    m_ext;
  logic [EXT-1:0]    q_ext;
  logic [AW-1:0]     m_wide;
  logic [AW-1:0]     addend;
  logic [AW-1:0]     sum;
  logic [AW+EXT-1:0] shifted;

  assign last = (cnt == CW'(ITER - 1));

  assign m_ext = bus.mode_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                 : {2'b00, bus.multiplicand};
  assign q_ext = bus.mode_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                 : {2'b00, bus.multiplier};

  assign m_wide  = {{2{m_reg[EXT-1]}}, m_reg};
  assign sum     = acc + addend;
  // Arithmetic shift of the combined {accumulator, multiplier} pair.
  assign shifted = $signed({sum, q_reg}) >>> 2;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // Booth recoding of the current 3-bit multiplier group into the addend.
  always_comb begin
    addend = '0;
    case ({q_reg[1:0], q_m1})
      3'b001, 3'b010: addend = m_wide;
      3'b011:         addend = m_wide << 1;
      3'b100:         addend = -(m_wide << 1);
      3'b101, 3'b110: addend = -m_wide;
      default:        addend = '0;
    endcase
  end

  // Operand capture, one Booth step per RUN cycle, result register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_reg       <= '0;
      q_reg       <= '0;
      q_m1        <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      bus.product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m_reg <= m_ext;
            q_reg <= q_ext;
            q_m1  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= shifted[AW+EXT-1:EXT];
          q_reg <= shifted[EXT-1:0];
          q_m1  <= q_reg[1];
          cnt   <= cnt + 1'b1;
          if (last) bus.product <= shifted[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_radix4_mult.sv
// Bench for booth_radix4_mult: 16-bit and 8-bit instances.
// Directed corner cases, then random operands against an arithmetic model.
// Summary line reports total checks and failures.
module tb_booth_radix4_mult;
  logic Clock;
  logic Reset_n;
  int   checks;
  int   failures;

  booth_radix4_mult_if #(.WIDTH(16)) bus16 ();
  booth_radix4_mult_if #(.WIDTH(8))  bus8 ();

  booth_radix4_mult #(.WIDTH(16)) d16 (.Clock(Clock), .Reset_n(Reset_n), .bus(bus16));
  booth_radix4_mult #(.WIDTH(8))  d8  (.Clock(Clock), .Reset_n(Reset_n), .bus(bus8));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Exact product of the operands as integers, truncated to 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input bit sgn,
                                           input logic [31:0] m, input logic [31:0] q);
    longint a;
    longint b;
    longint p;
    a = longint'(m) & ((longint'(1) << w) - 1);
    b = longint'(q) & ((longint'(1) << w) - 1);
    if (sgn) begin
      if (a >= (longint'(1) << (w - 1))) a = a - (longint'(1) << w);
      if (b >= (longint'(1) << (w - 1))) b = b - (longint'(1) << w);
    end
    p = a * b;
    return 64'(p) & ((64'd1 << (2 * w)) - 1);
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One 16-bit operation from IDLE; lat counts edges from the start edge.
  task automatic run16(input bit sgn, input logic [15:0] m, input logic [15:0] q,
                       output logic [31:0] p, output int lat, output int busy_n,
                       output bit held);
    logic [31:0] prev;
    bus16.mode_signed  = sgn;
    bus16.multiplicand = m;
    bus16.multiplier   = q;
    bus16.start        = 1'b1;
    prev   = bus16.product;
    held   = 1'b1;
    busy_n = 0;
    tick();
    bus16.start = 1'b0;
    lat = 0;
    while (bus16.done !== 1'b1 && lat < 40) begin
      if (bus16.busy === 1'b1) busy_n++;
      if (bus16.product !== prev) held = 1'b0;
      tick();
      lat++;
    end
    p = bus16.product;
    tick();
  endtask

  task automatic run8(input bit sgn, input logic [7:0] m, input logic [7:0] q,
                      output logic [15:0] p, output int lat);
    bus8.mode_signed  = sgn;
    bus8.multiplicand = m;
    bus8.multiplier   = q;
    bus8.start        = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    p = bus8.product;
    tick();
  endtask

  initial begin
    logic [31:0] p16;
    logic [15:0] p8;
    int          lat;
    int          busy_n;
    bit          held;
    int          dones;
    int          done_k;
    int          busy_after;
    int          d1;
    int          d2;

    checks   = 0;
    failures = 0;
    Reset_n  = 1'b0;
    bus16.start = 1'b0; bus16.mode_signed = 1'b0; bus16.multiplicand = '0; bus16.multiplier = '0;
    bus8.start  = 1'b0; bus8.mode_signed  = 1'b0; bus8.multiplicand  = '0; bus8.multiplier  = '0;

    #2;
    chk("reset_busy",      64'(bus16.busy),    64'd0);
    chk("reset_done",      64'(bus16.done),    64'd0);
    chk("reset_product",   64'(bus16.product), 64'd0);
    chk("reset_product8",  64'(bus8.product),  64'd0);

    // Release mid-cycle; the very next edge samples start.
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;

    run16(1'b1, 16'hFFFF, 16'hFFFF, p16, lat, busy_n, held);
    chk("s_ffff_prod", 64'(p16),    64'h0000_0001);
    chk("s_ffff_lat",  64'(lat),    64'd9);
    chk("s_ffff_busy", 64'(busy_n), 64'd9);
    chk("s_ffff_hold", 64'(held),   64'd1);

    run16(1'b0, 16'hFFFF, 16'hFFFF, p16, lat, busy_n, held);
    chk("u_ffff_prod", 64'(p16),  64'hFFFE_0001);
    chk("u_ffff_hold", 64'(held), 64'd1);

    run16(1'b1, 16'h8000, 16'h8000, p16, lat, busy_n, held);
    chk("s_8000_prod", 64'(p16), 64'h4000_0000);

    run16(1'b1, 16'h7FFF, 16'h8000, p16, lat, busy_n, held);
    chk("s_7fff_prod", 64'(p16), 64'hC000_8000);

    run16(1'b0, 16'h0000, 16'h1234, p16, lat, busy_n, held);
    chk("zero_prod", 64'(p16),    64'd0);
    chk("zero_lat",  64'(lat),    64'd9);
    chk("zero_busy", 64'(busy_n), 64'd9);

    run8(1'b0, 8'h80, 8'h80, p8, lat);
    chk("w8_80_prod", 64'(p8), 64'h4000);
    chk("w8_80_lat",  64'(lat), 64'd5);

    // Operand changes and a stray start during RUN must be ignored.
    bus16.mode_signed  = 1'b1;
    bus16.multiplicand = 16'd3;
    bus16.multiplier   = 16'd5;
    bus16.start        = 1'b1;
    tick();
    bus16.start = 1'b0;
    dones = 0; done_k = -1; busy_after = 0; p16 = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (bus16.done === 1'b1) begin
        dones++;
        done_k = k;
        p16 = bus16.product;
      end
      if (k >= 11 && bus16.busy !== 1'b0) busy_after++;
      if (k == 2) begin
        bus16.multiplicand = 16'h1234;
        bus16.multiplier   = 16'h1234;
      end
      if (k == 3) bus16.start = 1'b1;
      if (k == 4) bus16.start = 1'b0;
    end
    chk("ign_prod",       64'(p16),        64'h0000_000F);
    chk("ign_done_cnt",   64'(dones),      64'd1);
    chk("ign_done_cycle", 64'(done_k),     64'd9);
    chk("ign_no_second",  64'(busy_after), 64'd0);

    // Reset in the middle of a run aborts it without a done pulse.
    bus16.mode_signed  = 1'b1;
    bus16.multiplicand = 16'd7;
    bus16.multiplier   = 16'd9;
    bus16.start        = 1'b1;
    tick();
    bus16.start = 1'b0;
    repeat (5) tick();
    Reset_n = 1'b0;
    #1;
    chk("abort_busy",    64'(bus16.busy),    64'd0);
    chk("abort_done",    64'(bus16.done),    64'd0);
    chk("abort_product", 64'(bus16.product), 64'd0);
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus16.done !== 1'b0) dones++;
    end
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus16.done !== 1'b0 || bus16.busy !== 1'b0) dones++;
    end
    chk("abort_quiet", 64'(dones), 64'd0);
    run16(1'b1, 16'd3, 16'd5, p16, lat, busy_n, held);
    chk("after_abort_prod", 64'(p16), 64'h0000_000F);
    chk("after_abort_lat",  64'(lat), 64'd9);

    // start held high: operations back to back every ITER+2 cycles.
    bus16.mode_signed  = 1'b1;
    bus16.multiplicand = 16'hFFFE;
    bus16.multiplier   = 16'd3;
    bus16.start        = 1'b1;
    d1 = -1; d2 = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus16.done === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    bus16.start = 1'b0;
    repeat (12) tick();
    chk("b2b_period", 64'(d2 - d1),       64'd11);
    chk("b2b_prod",   64'(bus16.product), 64'hFFFF_FFFA);

    // Random operands on both widths and both modes, run concurrently.
    fork
      begin
        logic [15:0] rp;
        int          rl;
        bit          s;
        logic [7:0]  a;
        logic [7:0]  b;
        for (int i = 0; i < 10000; i++) begin
          s = 1'($urandom_range(0, 1));
          a = 8'($urandom);
          b = 8'($urandom);
          run8(s, a, b, rp, rl);
          chk("rand8_prod", 64'(rp), ref_prod(8, s, 32'(a), 32'(b)));
          chk("rand8_lat",  64'(rl), 64'd5);
        end
      end
      begin
        logic [31:0] rp;
        int          rl;
        int          rb;
        bit          rh;
        bit          s;
        logic [15:0] a;
        logic [15:0] b;
        for (int i = 0; i < 2000; i++) begin
          s = 1'($urandom_range(0, 1));
          a = 16'($urandom);
          b = 16'($urandom);
          run16(s, a, b, rp, rl, rb, rh);
          chk("rand16_prod", 64'(rp), ref_prod(16, s, 32'(a), 32'(b)));
          chk("rand16_lat",  64'(rl), 64'd9);
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
